// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder/subtractor: one full-adder cell plus a carry flop,
// one result bit per clock (LSB first), one-cycle done pulse with sum and carry-out.
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             sub_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] s_o,
  output logic             c_o
);

  localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] s_sh_q, s_sh_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             cy_q, cy_d;
  logic             c_q, c_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  logic s_bit;
  logic cy_next;

  // The single full-adder cell shared across all bit positions.
  assign s_bit   = a_q[0] ^ b_q[0] ^ cy_q;
  assign cy_next = (a_q[0] & b_q[0]) | (a_q[0] & cy_q) | (b_q[0] & cy_q);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    s_sh_d  = s_sh_q;
    s_d     = s_q;
    cy_d    = cy_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          a_d     = a_i;
          // Subtraction is A + ~B + 1, with the +1 injected as the initial carry.
          b_d     = sub_i ? ~b_i : b_i;
          cy_d    = sub_i;
          cnt_d   = '0;
          s_sh_d  = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        s_sh_d = {s_bit, s_sh_q[WIDTH-1:1]};
        a_d    = a_q >> 1;
        b_d    = b_q >> 1;
        cy_d   = cy_next;
        cnt_d  = cnt_q + CntW'(1);
        if (cnt_q == LastCnt) begin
          s_d     = {s_bit, s_sh_q[WIDTH-1:1]};
          c_d     = cy_next;
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      s_sh_q  <= '0;
      s_q     <= '0;
      cy_q    <= 1'b0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_sh_q  <= s_sh_d;
      s_q     <= s_d;
      cy_q    <= cy_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy_o = (state_q == StRun);
  assign done_o = (state_q == StDone);
  assign s_o    = s_q;
  assign c_o    = c_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed WIDTH=8 cases plus an
// exhaustive WIDTH=4 sweep, with results matched against a scoreboard queue.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst;
  logic       start8, sub8;
  logic [7:0] a8, b8;
  logic       busy8, done8, c8;
  logic [7:0] s8;
  logic       start4, sub4;
  logic [3:0] a4, b4;
  logic       busy4, done4, c4;
  logic [3:0] s4;

  int checks   = 0;
  int failures = 0;

  logic [8:0] q8[$];
  logic [4:0] q4[$];

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) u_dut8 (
    .clk_i   (clk),
    .rst_i   (rst),
    .start_i (start8),
    .sub_i   (sub8),
    .a_i     (a8),
    .b_i     (b8),
    .busy_o  (busy8),
    .done_o  (done8),
    .s_o     (s8),
    .c_o     (c8)
  );

  serial_adder #(.WIDTH(4)) u_dut4 (
    .clk_i   (clk),
    .rst_i   (rst),
    .start_i (start4),
    .sub_i   (sub4),
    .a_i     (a4),
    .b_i     (b4),
    .busy_o  (busy4),
    .done_o  (done4),
    .s_o     (s4),
    .c_o     (c4)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] model4(input logic [3:0] a, input logic [3:0] b,
                                        input logic sub);
    logic [3:0] nb;
    nb = ~b;
    if (sub) return {1'b0, a} + {1'b0, nb} + 5'd1;
    return {1'b0, a} + {1'b0, b};
  endfunction

  // Scoreboard: every DONE pops the oldest expected {C,S}; a DONE with nothing pending fails.
  always @(negedge clk) begin
    if (!rst && done8) begin
      if (q8.size() == 0) chk("unexpected_done8", 1, 0);
      else chk("result8", int'({c8, s8}), int'(q8.pop_front()));
    end
    if (!rst && done4) begin
      if (q4.size() == 0) chk("unexpected_done4", 1, 0);
      else chk("result4", int'({c4, s4}), int'(q4.pop_front()));
    end
  end

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic sub,
                     input logic [8:0] exp);
    int lat;
    int busy_n;
    a8 = a; b8 = b; sub8 = sub; start8 = 1'b1;
    q8.push_back(exp);
    @(posedge clk); #1;
    start8 = 1'b0;
    a8 = ~a; b8 = 8'h5a; sub8 = ~sub;  // operand changes during RUN must not matter
    lat = 0;
    busy_n = busy8 ? 1 : 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (done8) begin
        lat = i;
        break;
      end
      if (busy8) busy_n++;
    end
    chk("latency8", lat, 8);
    chk("busy_cycles8", busy_n, 8);
    @(posedge clk); #1;
    chk("done_drop8", int'(done8), 0);
    chk("hold8", int'({c8, s8}), int'(exp));
  endtask

  initial begin
    int dn;
    int lat;
    rst = 1'b1;
    start8 = 1'b0; sub8 = 1'b0; a8 = '0; b8 = '0;
    start4 = 1'b0; sub4 = 1'b0; a4 = '0; b4 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy8), 0);
    chk("rst_done", int'(done8), 0);
    chk("rst_s", int'(s8), 0);
    chk("rst_c", int'(c8), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    op8(8'd3,   8'd5,   1'b0, {1'b0, 8'd8});
    op8(8'd200, 8'd100, 1'b0, {1'b1, 8'd44});
    op8(8'd255, 8'd1,   1'b0, {1'b1, 8'd0});
    op8(8'd5,   8'd3,   1'b1, {1'b1, 8'd2});
    op8(8'd3,   8'd5,   1'b1, {1'b0, 8'd254});
    op8(8'd77,  8'd77,  1'b1, {1'b1, 8'd0});

    // Second START during RUN and during the DONE cycle must be ignored.
    a8 = 8'd10; b8 = 8'd20; sub8 = 1'b0; start8 = 1'b1;
    q8.push_back({1'b0, 8'd30});
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    a8 = 8'd99; b8 = 8'd1; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      if (done8) begin
        lat = 1;
        break;
      end
      @(posedge clk); #1;
    end
    chk("ignore_reached_done", lat, 1);
    a8 = 8'd1; b8 = 8'd1; sub8 = 1'b1; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    dn = 0;
    for (int i = 0; i < 15; i++) begin
      if (done8) dn++;
      @(posedge clk); #1;
    end
    chk("ignore_no_second_done", dn, 0);
    chk("ignore_result", int'({c8, s8}), int'({1'b0, 8'd30}));

    // Reset on the 4th RUN cycle aborts the op and clears S/C.
    a8 = 8'd7; b8 = 8'd9; sub8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_busy", int'(busy8), 0);
    chk("abort_done", int'(done8), 0);
    chk("abort_s", int'(s8), 0);
    chk("abort_c", int'(c8), 0);
    dn = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done8) dn++;
    end
    chk("abort_no_done", dn, 0);
    op8(8'd100, 8'd50, 1'b1, {1'b1, 8'd50});

    // Exhaustive WIDTH=4 sweep.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        for (int s = 0; s < 2; s++) begin
          a4 = 4'(a); b4 = 4'(b); sub4 = s[0]; start4 = 1'b1;
          q4.push_back(model4(4'(a), 4'(b), s[0]));
          @(posedge clk); #1;
          start4 = 1'b0;
          lat = 0;
          for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (done4) begin
              lat = i;
              break;
            end
          end
          if (lat != 4) chk("latency4", lat, 4);
          @(posedge clk); #1;
        end
      end
    end
    chk("q4_drained", q4.size(), 0);
    chk("q8_drained", q8.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
